// File: rtl/uart_line_fifo.sv
// FWFT byte FIFO behind uart_rx that frames bytes into eol-terminated lines and reports line count and overflow.
// Define UART_LINE_SUM_EN to build the per-line byte checksum (o_line_sum / o_sum_valid).
module uart_line_fifo #(
    parameter int unsigned depth    = 16,
    parameter logic [7:0]  eol_byte = 8'h0A
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               i_data,
    input  logic                     i_valid,
    input  logic                     i_rd,
    output logic [7:0]               o_data,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(depth):0]   o_count,
    output logic [$clog2(depth):0]   o_lines,
    output logic                     o_overflow,
    output logic [31:0]              o_line_sum,
    output logic                     o_sum_valid
);

    localparam int unsigned aw = $clog2(depth);
    localparam int unsigned cw = aw + 1;

    localparam logic [1:0] st_idle    = 2'd0;
    localparam logic [1:0] st_in_line = 2'd1;
    localparam logic [1:0] st_drop    = 2'd2;

    logic [7:0]    mem [depth];
    logic [aw-1:0] wr_ptr;
    logic [aw-1:0] rd_ptr;
    logic [aw-1:0] rd_ptr_next;
    logic [cw-1:0] count;
    logic [cw-1:0] count_next;
    logic [cw-1:0] lines;
    logic [cw-1:0] lines_next;
    logic [7:0]    head_next;
    logic [1:0]    state;
    logic [1:0]    state_next;

    logic pop_acc;
    logic has_room;
    logic is_eol;
    logic wr_acc;
    logic enter_drop;
    logic inc_line;
    logic dec_line;

    // Line framing FSM: decides whether each arriving byte is written or dropped
    always_comb begin
        state_next = state;
        wr_acc     = 1'b0;
        enter_drop = 1'b0;
        inc_line   = 1'b0;
        pop_acc    = i_rd && (count != '0);
        has_room   = (count < cw'(depth)) || pop_acc;
        is_eol     = (i_data == eol_byte);
        if (i_valid) begin
            case (state)
                st_drop: begin
                    if (is_eol) begin
                        state_next = st_idle;
                    end
                end
                default: begin
                    if (!has_room) begin
                        enter_drop = 1'b1;
                        state_next = st_drop;
                    end else begin
                        wr_acc = 1'b1;
                        if (is_eol) begin
                            inc_line   = 1'b1;
                            state_next = st_idle;
                        end else begin
                            state_next = st_in_line;
                        end
                    end
                end
            endcase
        end
    end

    // Next occupancy, line count and FWFT head (bypass when the write lands at the new head)
    always_comb begin
        dec_line    = pop_acc && (o_data == eol_byte);
        rd_ptr_next = pop_acc ? rd_ptr + aw'(1) : rd_ptr;

        count_next = count;
        case ({wr_acc, pop_acc})
            2'b10:   count_next = count + cw'(1);
            2'b01:   count_next = count - cw'(1);
            default: count_next = count;
        endcase

        lines_next = lines;
        case ({inc_line, dec_line})
            2'b10:   lines_next = lines + cw'(1);
            2'b01:   lines_next = lines - cw'(1);
            default: lines_next = lines;
        endcase

        if (count_next == '0) begin
            head_next = 8'h00;
        end else if (wr_acc && (rd_ptr_next == wr_ptr)) begin
            head_next = i_data;
        end else begin
            head_next = mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= st_idle;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            lines      <= '0;
            o_data     <= 8'h00;
            o_empty    <= 1'b1;
            o_full     <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + aw'(1);
            end
            rd_ptr  <= rd_ptr_next;
            count   <= count_next;
            lines   <= lines_next;
            o_data  <= head_next;
            o_empty <= (count_next == '0);
            o_full  <= (count_next == cw'(depth));
            if (enter_drop) begin
                o_overflow <= 1'b1;
            end
        end
    end

    // Storage array carries no reset; pointers and count define validity
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= i_data;
        end
    end

    assign o_count = count;
    assign o_lines = lines;

`ifdef UART_LINE_SUM_EN
    logic [31:0] acc;

    // Per-line checksum of written bytes; a dropped line never reports a sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            o_line_sum  <= '0;
            o_sum_valid <= 1'b0;
        end else begin
            o_sum_valid <= 1'b0;
            if (enter_drop) begin
                acc <= '0;
            end else if (wr_acc) begin
                if (is_eol) begin
                    o_line_sum  <= acc + 32'(eol_byte);
                    o_sum_valid <= 1'b1;
                    acc         <= '0;
                end else begin
                    acc <= acc + 32'(i_data);
                end
            end
        end
    end
`else
    assign o_line_sum  = 32'h0;
    assign o_sum_valid = 1'b0;
`endif

endmodule

// File: tb/tb_uart_line_fifo.sv
// Directed bench for uart_line_fifo: scoreboard queue of written bytes checked on every pop,
// plus a small line/overflow/checksum model compared at each check point.
module tb_uart_line_fifo;

    logic        clk;
    logic        rst_n;
    logic [7:0]  i_data;
    logic        i_valid;
    logic        i_rd;
    logic [7:0]  o_data;
    logic        o_empty;
    logic        o_full;
    logic [4:0]  o_count;
    logic [4:0]  o_lines;
    logic        o_overflow;
    logic [31:0] o_line_sum;
    logic        o_sum_valid;

    uart_line_fifo #(.depth(16), .eol_byte(8'h0A)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .i_rd       (i_rd),
        .o_data     (o_data),
        .o_empty    (o_empty),
        .o_full     (o_full),
        .o_count    (o_count),
        .o_lines    (o_lines),
        .o_overflow (o_overflow),
        .o_line_sum (o_line_sum),
        .o_sum_valid(o_sum_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    logic [7:0]  sb[$];
    int          mlines;
    bit          mdrop;
    bit          movf;
    logic [31:0] macc;
    logic [31:0] mline_sum;
    int          mpulses;

    always @(negedge clk) begin
        if (o_sum_valid === 1'b1) pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        mlines    = 0;
        mdrop     = 1'b0;
        movf      = 1'b0;
        macc      = '0;
        mline_sum = '0;
    endtask

    // One clock of stimulus, entered and left on a falling edge
    task automatic step(input logic v, input logic [7:0] d, input logic r);
        int          c0;
        bit          pop;
        logic [7:0]  exp_head;
        i_valid = v;
        i_data  = d;
        i_rd    = r;
        c0  = sb.size();
        pop = r && (c0 > 0);
        if (pop) begin
            exp_head = sb.pop_front();
            chk("pop_data", 32'(o_data), 32'(exp_head));
            if (exp_head == 8'h0A) mlines--;
        end
        if (v) begin
            if (mdrop) begin
                if (d == 8'h0A) mdrop = 1'b0;
            end else if (!(c0 < 16 || pop)) begin
                mdrop = 1'b1;
                movf  = 1'b1;
                macc  = '0;
            end else begin
                sb.push_back(d);
                if (d == 8'h0A) begin
                    mlines++;
                    mline_sum = macc + 32'h0A;
                    mpulses++;
                    macc = '0;
                end else begin
                    macc = macc + 32'(d);
                end
            end
        end
        @(negedge clk);
        i_valid = 1'b0;
        i_rd    = 1'b0;
        i_data  = 8'h00;
    endtask

    task automatic check_state(input string tag);
        logic [7:0] head;
        head = (sb.size() > 0) ? sb[0] : 8'h00;
        chk({tag, "_count"}, 32'(o_count), 32'(sb.size()));
        chk({tag, "_lines"}, 32'(o_lines), 32'(mlines));
        chk({tag, "_empty"}, 32'(o_empty), 32'(sb.size() == 0));
        chk({tag, "_full"},  32'(o_full),  32'(sb.size() == 16));
        chk({tag, "_ovf"},   32'(o_overflow), 32'(movf));
        chk({tag, "_data"},  32'(o_data), 32'(head));
`ifdef UART_LINE_SUM_EN
        chk({tag, "_sum"},   o_line_sum, mline_sum);
`else
        chk({tag, "_sum"},   o_line_sum, 32'h0);
`endif
    endtask

    initial begin
        mpulses = 0;
        model_reset();
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_rd    = 1'b0;
        i_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_state("reset");
        chk("reset_sumv", 32'(o_sum_valid), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // "AB\n" with no pops
        step(1'b1, 8'h41, 1'b0);
        step(1'b1, 8'h42, 1'b0);
        step(1'b1, 8'h0A, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("ab_count", 32'(o_count), 32'd3);
        chk("ab_lines", 32'(o_lines), 32'd1);
        chk("ab_data",  32'(o_data),  32'h41);
`ifdef UART_LINE_SUM_EN
        chk("ab_sum",    o_line_sum, 32'h8D);
        chk("ab_pulses", 32'(pulses), 32'd1);
`else
        chk("ab_pulses", 32'(pulses), 32'd0);
`endif
        check_state("ab");

        // Drain the line
        repeat (3) step(1'b0, 8'h00, 1'b1);
        chk("drain_empty", 32'(o_empty), 32'd1);
        chk("drain_lines", 32'(o_lines), 32'd0);
        chk("drain_data",  32'(o_data),  32'h0);
        step(1'b0, 8'h00, 1'b1);
        check_state("pop_empty");

        // Fill to full, then simultaneous write+pop while full
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
        check_state("full");
        chk("full_flag", 32'(o_full), 32'd1);
        step(1'b1, 8'h55, 1'b1);
        chk("fullrw_count", 32'(o_count), 32'd16);
        chk("fullrw_ovf",   32'(o_overflow), 32'd0);
        chk("fullrw_head",  32'(o_data), 32'h31);
        check_state("fullrw");

        // Overflow: 17th byte and its eol are dropped
        step(1'b1, 8'h66, 1'b0);
        step(1'b1, 8'h0A, 1'b0);
        chk("ovf_flag",  32'(o_overflow), 32'd1);
        chk("ovf_lines", 32'(o_lines), 32'd0);
        chk("ovf_full",  32'(o_full), 32'd1);
        check_state("ovf");

        // Make room and write "C\n"; FSM must be back in IDLE
        repeat (2) step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h43, 1'b0);
        step(1'b1, 8'h0A, 1'b0);
        chk("c_lines", 32'(o_lines), 32'd1);
`ifdef UART_LINE_SUM_EN
        chk("c_sum", o_line_sum, 32'h4D);
`endif
        check_state("c_line");

        // Drain everything, checking each byte
        while (sb.size() > 0) step(1'b0, 8'h00, 1'b1);
        check_state("drain_all");

        // Single eol written with a pop while empty, popped next cycle
        step(1'b1, 8'h0A, 1'b1);
        chk("eol_lines1", 32'(o_lines), 32'd1);
`ifdef UART_LINE_SUM_EN
        chk("eol_sum", o_line_sum, 32'h0A);
`endif
        step(1'b0, 8'h00, 1'b1);
        chk("eol_lines0", 32'(o_lines), 32'd0);
        check_state("eol");

        // Asynchronous reset mid-line
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h61 + i), 1'b0);
        chk("pre_rst_count", 32'(o_count), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_state("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        step(1'b1, 8'h5A, 1'b0);
        step(1'b1, 8'h0A, 1'b0);
        chk("z_count", 32'(o_count), 32'd2);
        chk("z_lines", 32'(o_lines), 32'd1);
        check_state("z_line");

        step(1'b0, 8'h00, 1'b0);
`ifdef UART_LINE_SUM_EN
        chk("pulse_total", 32'(pulses), 32'(mpulses));
`else
        chk("pulse_total", 32'(pulses), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
